// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared types and default widths for the register-bank sequencer
package banco_pkg;

   localparam int W_DEF = 4;
   localparam int A_DEF = 5;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_AND  = 2'b10,
      OP_PASS = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/module_alu_banco.sv
// rtl/module_alu_banco.sv - combinational ALU (ADD/SUB/AND/PASS), wrap-around arithmetic
// Macro SEQ_FLAGS_EN adds the carry/borrow output.
module module_alu_banco
   import banco_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  op_t          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef SEQ_FLAGS_EN
   output logic         carry,
`endif
   output logic [W-1:0] y
);

   // One extra bit holds carry/borrow only when something consumes it
`ifdef SEQ_FLAGS_EN
   localparam int XW = W + 1;
`else
   localparam int XW = W;
`endif

   logic [XW-1:0] w_ext;

   always_comb begin
      w_ext = '0;
      case (op)
         OP_ADD:  w_ext = XW'(a) + XW'(b);
         OP_SUB:  w_ext = XW'(a) - XW'(b);
         OP_AND:  w_ext = XW'(a & b);
         default: w_ext = XW'(a);
      endcase
   end

   assign y = w_ext[W-1:0];

`ifdef SEQ_FLAGS_EN
   assign carry = w_ext[XW-1];
`endif

endmodule

// File: rtl/module_secuenciador_banco.sv
// rtl/module_secuenciador_banco.sv - read/compute/write-back sequencer over an external register file
// Macro SEQ_FLAGS_EN adds the flag_z/flag_c outputs.
module module_secuenciador_banco
   import banco_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int A = A_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [A-1:0] req_rs1,
   input  logic [A-1:0] req_rs2,
   input  logic [A-1:0] req_rd,
   output logic         done,
   output logic [W-1:0] result,
`ifdef SEQ_FLAGS_EN
   output logic         flag_z,
   output logic         flag_c,
`endif
   output logic [A-1:0] rf_addr_rs1,
   output logic [A-1:0] rf_addr_rs2,
   output logic [A-1:0] rf_addr_rd,
   output logic [W-1:0] rf_data_in,
   output logic         rf_we,
   input  logic [W-1:0] rf_rs1,
   input  logic [W-1:0] rf_rs2
);

   state_t       r_state;
   state_t       w_next;
   op_t          r_op;
   logic [A-1:0] r_rs1;
   logic [A-1:0] r_rs2;
   logic [A-1:0] r_rd;
   logic [W-1:0] r_result;
   logic [W-1:0] w_alu_y;
   logic         w_accept;
`ifdef SEQ_FLAGS_EN
   logic         r_flag_z;
   logic         r_flag_c;
   logic         w_alu_c;
`endif

   module_alu_banco #(.W(W)) u_alu (
      .op    (r_op),
      .a     (rf_rs1),
      .b     (rf_rs2),
`ifdef SEQ_FLAGS_EN
      .carry (w_alu_c),
`endif
      .y     (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_ADD;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_rd     <= '0;
         r_result <= '0;
`ifdef SEQ_FLAGS_EN
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op  <= op_t'(req_op);
            r_rs1 <= req_rs1;
            r_rs2 <= req_rs2;
            r_rd  <= req_rd;
         end
         if (r_state == ST_READ) begin
            r_result <= w_alu_y;
`ifdef SEQ_FLAGS_EN
            r_flag_z <= (w_alu_y == '0);
            r_flag_c <= w_alu_c;
`endif
         end
      end
   end

   // Handshake and write strobe are qualified by rst so a reset edge never accepts or writes
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      w_accept  = 1'b0;
      rf_we     = 1'b0;
      done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = rst;
            w_accept  = req_valid && rst;
            if (w_accept) w_next = ST_READ;
         end
         ST_READ:  w_next = ST_WRITE;
         ST_WRITE: begin
            rf_we  = rst;
            w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   assign rf_addr_rs1 = r_rs1;
   assign rf_addr_rs2 = r_rs2;
   assign rf_addr_rd  = r_rd;
   assign rf_data_in  = r_result;
   assign result      = r_result;

`ifdef SEQ_FLAGS_EN
   assign flag_z = r_flag_z;
   assign flag_c = r_flag_c;
`endif

endmodule

// File: tb/tb_module_secuenciador_banco.sv
// tb/tb_module_secuenciador_banco.sv - table-driven bench with register-file model and done scoreboard
module tb_module_secuenciador_banco;

   localparam int W = 4;
   localparam int A = 5;

   typedef struct {
      logic [1:0]   op;
      logic [A-1:0] rs1;
      logic [A-1:0] rs2;
      logic [A-1:0] rd;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      logic         z;
      logic         c;
   } vec_t;

   typedef struct {
      logic [A-1:0] rd;
      logic [W-1:0] val;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [A-1:0] req_rs1;
   logic [A-1:0] req_rs2;
   logic [A-1:0] req_rd;
   logic         done;
   logic [W-1:0] result;
`ifdef SEQ_FLAGS_EN
   logic         flag_z;
   logic         flag_c;
`endif
   logic [A-1:0] rf_addr_rs1;
   logic [A-1:0] rf_addr_rs2;
   logic [A-1:0] rf_addr_rd;
   logic [W-1:0] rf_data_in;
   logic         rf_we;
   logic [W-1:0] rf_rs1;
   logic [W-1:0] rf_rs2;

   logic [W-1:0] rf [32];
   logic         pl_en = 1'b0;
   logic [A-1:0] pl_addr = '0;
   logic [W-1:0] pl_data = '0;

   int  n_checks = 0;
   int  n_errors = 0;
   int  we_cnt = 0;
   int  done_cnt = 0;
   sb_t sb_q[$];
   sb_t mon_e;
   vec_t vecs[10];

   always #5 clk = ~clk;

   module_secuenciador_banco #(.W(W), .A(A)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .req_rd      (req_rd),
      .done        (done),
      .result      (result),
`ifdef SEQ_FLAGS_EN
      .flag_z      (flag_z),
      .flag_c      (flag_c),
`endif
      .rf_addr_rs1 (rf_addr_rs1),
      .rf_addr_rs2 (rf_addr_rs2),
      .rf_addr_rd  (rf_addr_rd),
      .rf_data_in  (rf_data_in),
      .rf_we       (rf_we),
      .rf_rs1      (rf_rs1),
      .rf_rs2      (rf_rs2)
   );

   // Asynchronous-read register file; bench preload port has priority
   assign rf_rs1 = rf[rf_addr_rs1];
   assign rf_rs2 = rf[rf_addr_rs2];

   always @(posedge clk) begin
      if (pl_en) rf[pl_addr] <= pl_data;
      else if (rf_we) rf[rf_addr_rd] <= rf_data_in;
   end

   always @(posedge clk) begin
      if (rf_we) we_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: done pulse with no pending operation (t=%0t)", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_result", 32'(result), 32'(mon_e.val));
            chk("sb_rf_rd", 32'(rf[mon_e.rd]), 32'(mon_e.val));
         end
      end
   end

   task automatic preload(input logic [A-1:0] addr, input logic [W-1:0] data);
      pl_en   = 1'b1;
      pl_addr = addr;
      pl_data = data;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic drive_req(input logic [1:0] op, input logic [A-1:0] s1,
                            input logic [A-1:0] s2, input logic [A-1:0] d);
      req_op    = op;
      req_rs1   = s1;
      req_rs2   = s2;
      req_rd    = d;
      req_valid = 1'b1;
   endtask

   task automatic run_op(input vec_t v);
      sb_t e;
      preload(v.rs2, v.b);
      preload(v.rs1, v.a);
      drive_req(v.op, v.rs1, v.rs2, v.rd);
      #1;
      chk("ready_idle", 32'(req_ready), 1);
      e.rd  = v.rd;
      e.val = v.exp;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      chk("read_addr_rs1", 32'(rf_addr_rs1), 32'(v.rs1));
      chk("read_addr_rs2", 32'(rf_addr_rs2), 32'(v.rs2));
      chk("read_we_low", 32'(rf_we), 0);
      chk("read_ready_low", 32'(req_ready), 0);
      @(negedge clk);
      chk("write_we", 32'(rf_we), 1);
      chk("write_addr_rd", 32'(rf_addr_rd), 32'(v.rd));
      chk("write_data", 32'(rf_data_in), 32'(v.exp));
`ifdef SEQ_FLAGS_EN
      chk("flag_z", 32'(flag_z), 32'(v.z));
      chk("flag_c", 32'(flag_c), 32'(v.c));
`endif
      @(negedge clk);
      chk("done_pulse", 32'(done), 1);
      chk("done_we_low", 32'(rf_we), 0);
      @(negedge clk);
      chk("done_cleared", 32'(done), 0);
      chk("result_held", 32'(result), 32'(v.exp));
   endtask

   initial begin
      int n;
      int low_cycles;
      int we0;
      int d0;

      //          op     rs1    rs2    rd     a      b      exp    z     c
      vecs[0] = '{2'b00, 5'd1,  5'd2,  5'd4,  4'h5, 4'h3, 4'h8, 1'b0, 1'b0};
      vecs[1] = '{2'b01, 5'd1,  5'd2,  5'd6,  4'h3, 4'h5, 4'hE, 1'b0, 1'b1};
      vecs[2] = '{2'b00, 5'd1,  5'd2,  5'd1,  4'h9, 4'h7, 4'h0, 1'b1, 1'b1};
      vecs[3] = '{2'b11, 5'd2,  5'd0,  5'd3,  4'hA, 4'h5, 4'hA, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 5'd1,  5'd2,  5'd5,  4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
      vecs[5] = '{2'b10, 5'd7,  5'd7,  5'd8,  4'h6, 4'h6, 4'h6, 1'b0, 1'b0};
      vecs[6] = '{2'b01, 5'd25, 5'd26, 5'd27, 4'h7, 4'h7, 4'h0, 1'b1, 1'b0};
      vecs[7] = '{2'b00, 5'd10, 5'd11, 5'd12, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
      vecs[8] = '{2'b01, 5'd22, 5'd23, 5'd24, 4'h0, 4'h1, 4'hF, 1'b0, 1'b1};
      vecs[9] = '{2'b11, 5'd13, 5'd13, 5'd13, 4'h3, 4'h3, 4'h3, 1'b0, 1'b0};

      rst       = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_rs1   = '0;
      req_rs2   = '0;
      req_rd    = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready_low", 32'(req_ready), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_addr_rs1", 32'(rf_addr_rs1), 0);
      chk("rst_addr_rs2", 32'(rf_addr_rs2), 0);
      chk("rst_addr_rd", 32'(rf_addr_rd), 0);
      chk("rst_data_in", 32'(rf_data_in), 0);
      req_valid = 1'b0;
      rst       = 1'b1;
      #1;
      chk("ready_after_rst", 32'(req_ready), 1);
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      // Back-to-back requests with req_valid held high
      preload(5'd1, 4'h2);
      preload(5'd2, 4'h3);
      preload(5'd3, 4'h6);
      preload(5'd4, 4'h4);
      drive_req(2'b00, 5'd1, 5'd2, 5'd20);
      #1;
      chk("b2b_first_ready", 32'(req_ready), 1);
      sb_q.push_back('{5'd20, 4'h5});
      @(negedge clk);
      drive_req(2'b01, 5'd3, 5'd4, 5'd21);
      n = 1;
      low_cycles = 0;
      while (n < 12) begin
         #1;
         if (req_ready) break;
         low_cycles++;
         @(negedge clk);
         n++;
      end
      chk("b2b_accept_gap", 32'(n), 4);
      chk("b2b_ready_low_cycles", 32'(low_cycles), 3);
      sb_q.push_back('{5'd21, 4'h2});
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_r20", 32'(rf[20]), 5);
      chk("b2b_r21", 32'(rf[21]), 2);

      // Reset during READ aborts the operation
      preload(5'd14, 4'h1);
      preload(5'd15, 4'h2);
      preload(5'd16, 4'h7);
      we0 = we_cnt;
      d0  = done_cnt;
      drive_req(2'b00, 5'd14, 5'd15, 5'd16);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_rd_ready_low", 32'(req_ready), 0);
      chk("abort_rd_result", 32'(result), 0);
      chk("abort_rd_addr_rd", 32'(rf_addr_rd), 0);
      rst = 1'b1;
      #1;
      chk("abort_rd_idle", 32'(req_ready), 1);
      repeat (4) @(negedge clk);
      chk("abort_rd_no_we", 32'(we_cnt - we0), 0);
      chk("abort_rd_no_done", 32'(done_cnt - d0), 0);
      chk("abort_rd_r16", 32'(rf[16]), 7);

      // Reset during WRITE must suppress the write at the reset edge
      preload(5'd17, 4'h1);
      preload(5'd18, 4'h1);
      preload(5'd19, 4'h9);
      we0 = we_cnt;
      d0  = done_cnt;
      drive_req(2'b00, 5'd17, 5'd18, 5'd19);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_wr_we_before", 32'(rf_we), 1);
      rst = 1'b0;
      #1;
      chk("abort_wr_we_gated", 32'(rf_we), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_wr_no_we", 32'(we_cnt - we0), 0);
      chk("abort_wr_no_done", 32'(done_cnt - d0), 0);
      chk("abort_wr_r19", 32'(rf[19]), 9);

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
